uart_rx_stream: RTL and testbench
=================================

# uart_rx_stream

UART receiver for the FPGA side of the debug serial link. It takes the host-driven serial line (`UART_TXD_IN`), deserialises 8N1 frames, and buffers received bytes in a small FIFO. Bytes are presented on a valid/ready byte stream to the on-chip console/command logic. It complements the existing UART transmit path that drives `UART_RXD_OUT`.

## Interface
- `CLK_HZ`, 200000000: frequency of `FPGA_SYSCLK` in Hz.
- `BAUD`, 115200: line rate. `CLKS_PER_BIT = CLK_HZ / BAUD`, integer-truncated; must be ≥ 8.
- `FIFO_DEPTH`, 16: receive FIFO entries; power of two, ≥ 2.
- `FPGA_SYSCLK`, in, 1: single system clock; all logic on its rising edge.
- `RESET`, in, 1: asynchronous, active-high reset.
- `UART_TXD_IN`, in, 1: serial line from host; asynchronous; idle high.
- `M_TDATA`, out, 8: byte at FIFO head.
- `M_TVALID`, out, 1: FIFO non-empty.
- `M_TREADY`, in, 1: consumer accepts the head byte when it is high together with `M_TVALID`.
- `FRAME_ERR`, out, 1: one-cycle pulse when a frame is discarded for a bad stop bit.
- `OVERRUN`, out, 1: one-cycle pulse when a good byte is dropped because the FIFO is full.
- `FIFO_LEVEL`, out, $clog2(FIFO_DEPTH)+1: current occupancy.

## Operation
- **Input synchroniser:** `UART_TXD_IN` passes through a 2-FF synchroniser, reset to 1. All decisions use the synchronised signal `rxs`.
- **Bit counter:** `bit_cnt` counts 0..CLKS_PER_BIT-1.
- **State machine:**
  - IDLE: when `rxs` = 0, go to START and load the counter for a half-bit wait of `CLKS_PER_BIT/2` cycles.
  - START: at the half-bit point, if `rxs` = 0 go to DATA and reload a full bit period. If `rxs` = 1 it is a glitch: go to IDLE with no pulse.
  - DATA: sample `rxs` every `CLKS_PER_BIT` cycles, 8 samples, LSB first, into the shift register. After the 8th sample go to STOP.
  - STOP: sample one bit period later, then return to IDLE.
    - Sample = 1 and FIFO not full: write the byte.
    - Sample = 1 and FIFO full: pulse `OVERRUN`; the byte is dropped and FIFO contents are unchanged.
    - Sample = 0: pulse `FRAME_ERR`; nothing is written. Return to IDLE, which waits for `rxs` high before arming start detection (break condition does not retrigger).
- **FIFO:** circular buffer with read/write pointers one bit wider than the index. Full and empty are decided by comparing the pointer MSB and index bits. Pointers wrap modulo `2*FIFO_DEPTH`.
- **Simultaneous events:**
  - Write and pop in the same cycle with FIFO full: the pop frees the slot, the write succeeds, no `OVERRUN`, and the level is unchanged.
  - Write and pop with FIFO empty: the write lands and the pop is ignored, since `M_TVALID` was low.
- **Output hold:** `M_TDATA`/`M_TVALID` stay stable while `M_TVALID` = 1 and `M_TREADY` = 0.
- **Reset:** `RESET` mid-frame aborts the frame immediately. State goes to IDLE, counters and pointers clear, and the partial byte is discarded.

## Timing
- **Reset values:**
  - `M_TVALID` = 0
  - `M_TDATA` = 0x00
  - `FRAME_ERR` = 0
  - `OVERRUN` = 0
  - `FIFO_LEVEL` = 0
  - synchroniser FFs = 1
  - state = IDLE
- **Line-to-logic latency:** 2 cycles from the `UART_TXD_IN` edge to `rxs`.
- **Write latency:**
  - The FIFO write happens on the clock edge of the stop-bit sample.
  - `M_TVALID` and `FIFO_LEVEL` reflect the write in the next cycle.
  - `FRAME_ERR` and `OVERRUN` are registered and high for exactly the cycle after the stop sample.
- **Sample points:** relative to the synchronised start edge, the start check is at CLKS_PER_BIT/2 and data bit k is at (k+1.5)·CLKS_PER_BIT.
- **Throughput:** back-to-back frames with zero idle between stop and the next start are received without loss.
- **Pop:** a pop on cycle N updates `M_TDATA` (next entry) and `FIFO_LEVEL` on cycle N+1. Sustained one pop per cycle is supported.

## Test plan
All scenarios use `CLK_HZ`=200000000, `BAUD`=12500000 (CLKS_PER_BIT=16), `FIFO_DEPTH`=4.
- **Single byte:** send 0xA5 (8N1) with `M_TREADY`=1 → `M_TVALID` high for 1 cycle with `M_TDATA`=0xA5, no error pulses, level returns to 0.
- **Glitch and framing:** a 4-cycle low glitch on an idle line → no valid, no pulse. Then send 0x3C with stop bit forced 0 → one `FRAME_ERR` pulse, FIFO unchanged; the next good byte 0x5A is received correctly after the line returns high.
- **Overrun:** with `M_TREADY`=0, send 0x01..0x05 back-to-back → `FIFO_LEVEL`=4 and one `OVERRUN` pulse at the 5th stop. Then drain with `M_TREADY`=1 → bytes 0x01,0x02,0x03,0x04 in order.
- **Full boundary with simultaneous pop:** FIFO holds 4, assert a single-cycle pop on the stop-sample cycle of byte 0x77 → no `OVERRUN`, level stays 4, 0x77 is last out.
- **Pointer wrap:** stream 10 bytes 0x10..0x19 with `M_TREADY` toggling every other cycle → all 10 received in order, level never exceeds 4.
- **Reset mid-frame:** assert `RESET` during data bit 3 of 0xFF → all outputs at reset values immediately. After release, a following 0x42 is received correctly.

Source files
------------

// File: rtl/uart_rx_stream.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_stream
// Description : 8N1 UART receiver with a 2-FF input synchroniser, mid-bit
//               sampling and a small receive FIFO presented as a valid/ready
//               byte stream. Bad stop bits and FIFO-full drops are reported
//               as single-cycle pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_stream #(
    parameter int CLK_HZ     = 200000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          FPGA_SYSCLK,
    input  logic                          RESET,
    input  logic                          UART_TXD_IN,
    output logic [7:0]                    M_TDATA,
    output logic                          M_TVALID,
    input  logic                          M_TREADY,
    output logic                          FRAME_ERR,
    output logic                          OVERRUN,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int AW           = $clog2(FIFO_DEPTH);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Receiver signals
    // ------------------------------------------------------------------
    logic             sync1;
    logic             rxs;
    state_t           state, state_n;
    logic [CNT_W-1:0] bit_cnt, bit_cnt_n;
    logic [2:0]       bit_idx, bit_idx_n;
    logic [7:0]       shift, shift_n;
    logic             wait_high, wait_high_n;
    logic             stop_ok;
    logic             stop_bad;

    // ------------------------------------------------------------------
    // FIFO signals
    // ------------------------------------------------------------------
    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        empty;
    logic        full;
    logic        pop;
    logic        do_write;
    logic        drop;

    // Two-stage synchroniser for the asynchronous serial line, idle high.
    always_ff @(posedge FPGA_SYSCLK or posedge RESET) begin
        if (RESET) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            sync1 <= UART_TXD_IN;
            rxs   <= sync1;
        end
    end

    // Receiver state register and bit timing counters.
    always_ff @(posedge FPGA_SYSCLK or posedge RESET) begin
        if (RESET) begin
            state     <= S_IDLE;
            bit_cnt   <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            wait_high <= 1'b0;
        end else begin
            state     <= state_n;
            bit_cnt   <= bit_cnt_n;
            bit_idx   <= bit_idx_n;
            shift     <= shift_n;
            wait_high <= wait_high_n;
        end
    end

    // Next-state logic: half-bit start check, 8 data samples, stop sample.
    always_comb begin
        state_n     = state;
        bit_cnt_n   = bit_cnt;
        bit_idx_n   = bit_idx;
        shift_n     = shift;
        wait_high_n = wait_high;
        stop_ok     = 1'b0;
        stop_bad    = 1'b0;
        case (state)
            S_IDLE: begin
                bit_cnt_n = '0;
                bit_idx_n = '0;
                // After a framing error the line must go high again before a
                // new start bit is accepted, so a held break does not retrigger.
                if (rxs) begin
                    wait_high_n = 1'b0;
                end else if (!wait_high) begin
                    state_n = S_START;
                end
            end
            S_START: begin
                if (bit_cnt == HALF_LAST) begin
                    bit_cnt_n = '0;
                    state_n   = rxs ? S_IDLE : S_DATA;
                end else begin
                    bit_cnt_n = bit_cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (bit_cnt == BIT_LAST) begin
                    bit_cnt_n = '0;
                    shift_n   = {rxs, shift[7:1]};
                    if (bit_idx == 3'd7) begin
                        state_n = S_STOP;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end else begin
                    bit_cnt_n = bit_cnt + 1'b1;
                end
            end
            S_STOP: begin
                if (bit_cnt == BIT_LAST) begin
                    bit_cnt_n = '0;
                    state_n   = S_IDLE;
                    if (rxs) begin
                        stop_ok = 1'b1;
                    end else begin
                        stop_bad    = 1'b1;
                        wait_high_n = 1'b1;
                    end
                end else begin
                    bit_cnt_n = bit_cnt + 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // FIFO status. A pop in the same cycle as a write to a full FIFO frees
    // the slot being written, so that write is accepted.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop      = M_TVALID && M_TREADY;
    assign do_write = stop_ok && (!full || pop);
    assign drop     = stop_ok && full && !pop;

    // FIFO pointers and the registered error pulses.
    always_ff @(posedge FPGA_SYSCLK or posedge RESET) begin
        if (RESET) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            FRAME_ERR <= 1'b0;
            OVERRUN   <= 1'b0;
        end else begin
            if (do_write) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            FRAME_ERR <= stop_bad;
            OVERRUN   <= drop;
        end
    end

    // FIFO storage; contents are only visible through valid pointers.
    always_ff @(posedge FPGA_SYSCLK) begin
        if (do_write) begin
            mem[wr_ptr[AW-1:0]] <= shift;
        end
    end

    assign M_TVALID   = !empty;
    assign M_TDATA    = M_TVALID ? mem[rd_ptr[AW-1:0]] : 8'h00;
    assign FIFO_LEVEL = wr_ptr - rd_ptr;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_stream
// Description : Directed self-checking bench for uart_rx_stream
//               (CLKS_PER_BIT = 16, FIFO_DEPTH = 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_stream;

    logic       FPGA_SYSCLK;
    logic       RESET;
    logic       UART_TXD_IN;
    logic [7:0] M_TDATA;
    logic       M_TVALID;
    logic       M_TREADY;
    logic       FRAME_ERR;
    logic       OVERRUN;
    logic [2:0] FIFO_LEVEL;

    int checks;
    int errors;

    // Monitor state, written only by the monitor process.
    logic [7:0] got [$];
    int         fe_cnt;
    int         ov_cnt;
    int         valid_cycles;

    uart_rx_stream #(
        .CLK_HZ     (200000000),
        .BAUD       (12500000),
        .FIFO_DEPTH (4)
    ) dut (
        .FPGA_SYSCLK (FPGA_SYSCLK),
        .RESET       (RESET),
        .UART_TXD_IN (UART_TXD_IN),
        .M_TDATA     (M_TDATA),
        .M_TVALID    (M_TVALID),
        .M_TREADY    (M_TREADY),
        .FRAME_ERR   (FRAME_ERR),
        .OVERRUN     (OVERRUN),
        .FIFO_LEVEL  (FIFO_LEVEL)
    );

    initial FPGA_SYSCLK = 1'b0;
    always #5 FPGA_SYSCLK = ~FPGA_SYSCLK;

    // Observe accepted bytes and pulse counts mid-cycle.
    always @(negedge FPGA_SYSCLK) begin
        if (!RESET) begin
            if (M_TVALID && M_TREADY) got.push_back(M_TDATA);
            if (FRAME_ERR) fe_cnt <= fe_cnt + 1;
            if (OVERRUN)   ov_cnt <= ov_cnt + 1;
            if (M_TVALID)  valid_cycles <= valid_cycles + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge FPGA_SYSCLK);
            #1;
        end
    endtask

    // One 160-cycle 8N1 frame. rdy_mode: 0 keep M_TREADY, 1 toggle every
    // cycle, 2 single-cycle pop aligned with the stop-sample edge.
    task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                              input int rdy_mode, output int max_lvl);
        logic [9:0] bits;
        bits    = {stop_bit, data, 1'b0};
        max_lvl = 0;
        for (int c = 0; c < 160; c++) begin
            UART_TXD_IN = bits[c/16];
            if (rdy_mode == 1) M_TREADY = ~M_TREADY;
            if (rdy_mode == 2) M_TREADY = (c == 154);
            @(posedge FPGA_SYSCLK);
            #1;
            if (int'(FIFO_LEVEL) > max_lvl) max_lvl = int'(FIFO_LEVEL);
        end
        if (rdy_mode == 2) M_TREADY = 1'b0;
    endtask

    initial begin
        int base;
        int fe0;
        int ov0;
        int vc0;
        int lvl;
        checks       = 0;
        errors       = 0;
        fe_cnt       = 0;
        ov_cnt       = 0;
        valid_cycles = 0;
        RESET        = 1'b1;
        UART_TXD_IN  = 1'b1;
        M_TREADY     = 1'b0;
        tick(3);

        // Reset state
        check("rst_valid", 32'(M_TVALID), 32'h0);
        check("rst_data",  32'(M_TDATA), 32'h00);
        check("rst_fe",    32'(FRAME_ERR), 32'h0);
        check("rst_ov",    32'(OVERRUN), 32'h0);
        check("rst_level", 32'(FIFO_LEVEL), 32'h0);
        RESET = 1'b0;
        tick(5);

        // Single byte with consumer always ready
        M_TREADY = 1'b1;
        base = got.size(); fe0 = fe_cnt; ov0 = ov_cnt; vc0 = valid_cycles;
        send_frame(8'hA5, 1'b1, 0, lvl);
        tick(4);
        check("single_count", 32'(got.size() - base), 32'd1);
        if (got.size() > base) check("single_data", 32'(got[base]), 32'hA5);
        check("single_vcyc", 32'(valid_cycles - vc0), 32'd1);
        check("single_fe", 32'(fe_cnt - fe0), 32'd0);
        check("single_ov", 32'(ov_cnt - ov0), 32'd0);
        check("single_level", 32'(FIFO_LEVEL), 32'h0);

        // Short low glitch on an idle line
        base = got.size(); fe0 = fe_cnt; vc0 = valid_cycles;
        UART_TXD_IN = 1'b0;
        tick(4);
        UART_TXD_IN = 1'b1;
        tick(30);
        check("glitch_valid", 32'(valid_cycles - vc0), 32'd0);
        check("glitch_fe", 32'(fe_cnt - fe0), 32'd0);

        // Bad stop bit followed by a held break, then a good byte
        send_frame(8'h3C, 1'b0, 0, lvl);
        tick(32);
        check("frame_fe", 32'(fe_cnt - fe0), 32'd1);
        check("frame_nodata", 32'(got.size() - base), 32'd0);
        check("frame_level", 32'(FIFO_LEVEL), 32'h0);
        UART_TXD_IN = 1'b1;
        tick(20);
        send_frame(8'h5A, 1'b1, 0, lvl);
        tick(4);
        check("after_fe_count", 32'(got.size() - base), 32'd1);
        if (got.size() > base) check("after_fe_data", 32'(got[base]), 32'h5A);
        check("after_fe_fe", 32'(fe_cnt - fe0), 32'd1);

        // Overrun: five back-to-back bytes into a 4-deep FIFO
        M_TREADY = 1'b0;
        base = got.size(); ov0 = ov_cnt;
        for (int b = 1; b <= 5; b++) send_frame(8'(b), 1'b1, 0, lvl);
        check("ovr_level", 32'(FIFO_LEVEL), 32'd4);
        check("ovr_pulse", 32'(ov_cnt - ov0), 32'd1);
        check("ovr_hold_data", 32'(M_TDATA), 32'h01);
        check("ovr_hold_valid", 32'(M_TVALID), 32'h1);
        M_TREADY = 1'b1;
        tick(10);
        check("ovr_drain_count", 32'(got.size() - base), 32'd4);
        for (int i = 0; i < 4; i++)
            if (got.size() > base + i) check("ovr_drain_data", 32'(got[base+i]), 32'(i + 1));
        check("ovr_drain_level", 32'(FIFO_LEVEL), 32'h0);

        // Full FIFO with a pop on the stop-sample cycle
        M_TREADY = 1'b0;
        base = got.size(); ov0 = ov_cnt;
        for (int b = 0; b < 4; b++) send_frame(8'h60 + 8'(b), 1'b1, 0, lvl);
        check("fullpop_pre_level", 32'(FIFO_LEVEL), 32'd4);
        send_frame(8'h77, 1'b1, 2, lvl);
        check("fullpop_level", 32'(FIFO_LEVEL), 32'd4);
        check("fullpop_ov", 32'(ov_cnt - ov0), 32'd0);
        M_TREADY = 1'b1;
        tick(10);
        check("fullpop_count", 32'(got.size() - base), 32'd5);
        if (got.size() >= base + 5) begin
            check("fullpop_first", 32'(got[base]), 32'h60);
            check("fullpop_mid", 32'(got[base+3]), 32'h63);
            check("fullpop_last", 32'(got[base+4]), 32'h77);
        end

        // Pointer wrap: ten bytes with ready toggling every cycle
        base = got.size(); ov0 = ov_cnt;
        begin
            int mx;
            mx = 0;
            for (int b = 0; b < 10; b++) begin
                send_frame(8'h10 + 8'(b), 1'b1, 1, lvl);
                if (lvl > mx) mx = lvl;
            end
            M_TREADY = 1'b1;
            tick(6);
            check("wrap_maxlvl_ok", 32'(mx <= 4), 32'h1);
        end
        check("wrap_count", 32'(got.size() - base), 32'd10);
        for (int i = 0; i < 10; i++)
            if (got.size() > base + i) check("wrap_data", 32'(got[base+i]), 32'h10 + 32'(i));
        check("wrap_ov", 32'(ov_cnt - ov0), 32'd0);

        // Reset in the middle of data bit 3 with a byte already queued
        M_TREADY = 1'b0;
        send_frame(8'h99, 1'b1, 0, lvl);
        check("prerst_data", 32'(M_TDATA), 32'h99);
        for (int c = 0; c < 70; c++) begin
            UART_TXD_IN = (c < 16) ? 1'b0 : 1'b1;
            tick(1);
        end
        RESET       = 1'b1;
        UART_TXD_IN = 1'b1;
        #1;
        check("midrst_valid", 32'(M_TVALID), 32'h0);
        check("midrst_data", 32'(M_TDATA), 32'h00);
        check("midrst_level", 32'(FIFO_LEVEL), 32'h0);
        check("midrst_fe", 32'(FRAME_ERR), 32'h0);
        check("midrst_ov", 32'(OVERRUN), 32'h0);
        tick(2);
        RESET = 1'b0;
        tick(20);
        M_TREADY = 1'b1;
        base = got.size(); fe0 = fe_cnt;
        send_frame(8'h42, 1'b1, 0, lvl);
        tick(4);
        check("postrst_count", 32'(got.size() - base), 32'd1);
        if (got.size() > base) check("postrst_data", 32'(got[base]), 32'h42);
        check("postrst_fe", 32'(fe_cnt - fe0), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
